// File: rtl/srpt_grant_pkts.sv
// -----------------------------------------------------------------------------
// srpt_grant_pkts
//   Receiver-side SRPT grant scheduler. Data-packet headers are popped from a
//   first-word-fall-through FIFO, merged into a small priority queue keyed by
//   {peer_id, local_id} and kept sorted by bytes remaining (ascending, ties in
//   insertion order). Each cycle the head-most entry with an unsent grant is
//   written to the grant FIFO.
//
// Ports
//   ap_clk / ap_rst        clock, asynchronous active-low reset
//   ap_ce                  clock enable (0 freezes every register)
//   ap_start               allows header reads and grant writes
//   ap_continue            done acknowledge (no effect in this block)
//   ap_idle/ap_done/ap_ready  block-level status (done = grant write,
//                          ready = header read)
//   header_in_*            FWFT header FIFO: empty flag, pop, 125-bit word
//   grant_pkt_*            grant FIFO: full flag (input), push, 95-bit word
// -----------------------------------------------------------------------------
module srpt_grant_pkts #(
  parameter int          MAX_ENTRIES = 8,
  parameter logic [31:0] RTT_BYTES   = 32'd5000
) (
  input  logic         ap_clk,
  input  logic         ap_rst,
  input  logic         ap_ce,
  input  logic         ap_start,
  input  logic         ap_continue,
  output logic         ap_idle,
  output logic         ap_done,
  output logic         ap_ready,
  input  logic         header_in_empty_i,
  output logic         header_in_read_en_o,
  input  logic [124:0] header_in_data_i,
  input  logic         grant_pkt_full_o,
  output logic         grant_pkt_write_en_o,
  output logic [94:0]  grant_pkt_data_o
);

  localparam int IW = $clog2(MAX_ENTRIES);
  localparam int CW = IW + 1;

  typedef struct packed {
    logic [28:0] key;    // {peer_id, local_id}
    logic [31:0] rem;    // bytes remaining (sort key)
    logic [31:0] grant;  // highest grant offset issued or owed
    logic [31:0] len;    // message length
  } entry_t;

  // Queue state: always compact, entries 0..count-1 valid, sorted by rem.
  logic [MAX_ENTRIES-1:0] r_vld;
  logic [MAX_ENTRIES-1:0] r_pend;
  entry_t                 r_ent [MAX_ENTRIES];
  logic                   r_hdr_vld;
  logic [124:0]           r_hdr;
  logic [94:0]            r_gdata;

  logic            w_unused_continue;
  logic [CW-1:0]   w_cnt;
  logic            w_gfound;
  logic [IW-1:0]   w_gidx;
  logic            w_gnt_fire;
  logic            w_retire;
  entry_t          w_gent;
  logic [1:0]      w_gprio;
  logic [94:0]     w_gword;
  logic            w_rd;
  logic            w_im;

  logic [28:0]     w_h_key;
  logic [31:0]     w_h_len, w_h_inc, w_h_off, w_h_rem, w_h_grant;
  logic [32:0]     w_h_sum;
  logic            w_proc;
  logic            w_hm;
  logic [IW-1:0]   w_hidx;
  entry_t          w_old;
  logic            w_old_p;
  logic [31:0]     w_m_grant;
  logic            w_m_pend;
  logic            w_do_ins;
  entry_t          w_new;

  logic [MAX_ENTRIES-1:0] w_rm, w_pend_a;
  entry_t                 w_c_ent [MAX_ENTRIES];
  logic [MAX_ENTRIES-1:0] w_c_pend;
  logic [CW-1:0]          w_c_num, w_pos, w_n_cnt;
  entry_t                 w_n_ent [MAX_ENTRIES];
  logic [MAX_ENTRIES-1:0] w_n_pend, w_n_vld;

  assign w_unused_continue = ap_continue;

  // ---------------------------------------------------------------------------
  // Grant selection: first pending entry from the head.
  // ---------------------------------------------------------------------------
  // NOTE: combinational processes use blocking assignments and give every
  // output a default first, so no latch is inferred on any path.
  always_comb begin : grant_select
    w_cnt    = '0;
    w_gfound = 1'b0;
    w_gidx   = '0;
    for (int i = 0; i < MAX_ENTRIES; i++) begin
      if (r_vld[i]) w_cnt = w_cnt + CW'(1);
      if (!w_gfound && r_vld[i] && r_pend[i]) begin
        w_gfound = 1'b1;
        w_gidx   = IW'(i);
      end
    end
  end

  assign w_gnt_fire = ap_rst & ap_ce & ap_start & ~grant_pkt_full_o & w_gfound;
  assign w_gent     = r_ent[w_gidx];
  assign w_retire   = w_gnt_fire & (w_gent.grant == w_gent.len);
  assign w_gprio    = (w_gidx > IW'(2)) ? 2'd3 : w_gidx[1:0];
  assign w_gword    = {w_gent.key, w_gent.grant, w_gent.rem, w_gprio};

  // ---------------------------------------------------------------------------
  // Decode of the header captured last cycle.
  // ---------------------------------------------------------------------------
  assign w_h_key   = r_hdr[124:96];
  assign w_h_len   = r_hdr[95:64];
  assign w_h_inc   = r_hdr[63:32];
  assign w_h_off   = r_hdr[31:0];
  assign w_h_rem   = (w_h_off > w_h_len) ? 32'd0 : (w_h_len - w_h_off);
  assign w_h_sum   = {1'b0, w_h_off} + {1'b0, RTT_BYTES};
  assign w_h_grant = (w_h_sum > {1'b0, w_h_len}) ? w_h_len : w_h_sum[31:0];
  assign w_proc    = ap_ce & r_hdr_vld;

  // Key lookups. The captured header only matches entries that survive this
  // cycle's grant; the FIFO head may match any live entry, which is what lets
  // an update in while the queue is full.
  always_comb begin : key_lookup
    w_hm   = 1'b0;
    w_hidx = '0;
    w_im   = 1'b0;
    for (int i = 0; i < MAX_ENTRIES; i++) begin
      if (r_vld[i] && !(w_retire && w_gidx == IW'(i)) &&
          r_ent[i].key == w_h_key && !w_hm) begin
        w_hm   = 1'b1;
        w_hidx = IW'(i);
      end
      if (r_vld[i] && r_ent[i].key == header_in_data_i[124:96]) w_im = 1'b1;
    end
  end

  // Merge with an existing entry: the grant never moves backwards, and the
  // entry owes a grant only if it is ahead of what the sender holds and is
  // either new, larger than before, or still unsent. A grant issued in this
  // very cycle has already consumed the old pending flag.
  assign w_old     = r_ent[w_hidx];
  assign w_old_p   = r_pend[w_hidx] & ~(w_gnt_fire & (w_gidx == w_hidx));
  assign w_m_grant = (w_hm && w_old.grant > w_h_grant) ? w_old.grant : w_h_grant;
  assign w_m_pend  = (w_m_grant > w_h_inc) &&
                     (!w_hm || (w_m_grant > w_old.grant) || w_old_p);
  // A matched entry with nothing owed and nothing left to grant is dropped.
  assign w_do_ins  = w_proc & (w_hm ? (w_m_pend | (w_m_grant != w_h_len)) : w_m_pend);
  assign w_new     = '{key: w_h_key, rem: w_h_rem, grant: w_m_grant, len: w_h_len};

  // Read gate counts the header still in flight so a slot is always free for it.
  assign w_rd = ap_rst & ap_ce & ap_start & ~header_in_empty_i &
                (((w_cnt + CW'(r_hdr_vld)) < CW'(MAX_ENTRIES)) | w_im);

  // ---------------------------------------------------------------------------
  // Next queue: drop retired/updated entries, compact, then re-insert the
  // header entry behind every entry with rem <= its own (keeps tie order).
  // ---------------------------------------------------------------------------
  always_comb begin : remove_mask
    for (int i = 0; i < MAX_ENTRIES; i++) begin
      w_rm[i]     = (w_retire && w_gidx == IW'(i)) ||
                    (w_proc && w_hm && w_hidx == IW'(i));
      w_pend_a[i] = r_pend[i] && !(w_gnt_fire && w_gidx == IW'(i));
    end
  end

  always_comb begin : compact
    w_c_num  = '0;
    w_c_pend = '0;
    for (int i = 0; i < MAX_ENTRIES; i++) w_c_ent[i] = '0;
    for (int j = 0; j < MAX_ENTRIES; j++) begin
      if (r_vld[j] && !w_rm[j]) begin
        w_c_ent[w_c_num[IW-1:0]]  = r_ent[j];
        w_c_pend[w_c_num[IW-1:0]] = w_pend_a[j];
        w_c_num = w_c_num + CW'(1);
      end
    end
  end

  always_comb begin : insert_pos
    w_pos = '0;
    for (int i = 0; i < MAX_ENTRIES; i++) begin
      if (CW'(i) < w_c_num && w_c_ent[i].rem <= w_h_rem) w_pos = CW'(i + 1);
    end
  end

  assign w_n_cnt = w_c_num + CW'(w_do_ins);

  always_comb begin : build_next
    for (int i = 0; i < MAX_ENTRIES; i++) begin
      if (!w_do_ins || CW'(i) < w_pos) begin
        w_n_ent[i]  = w_c_ent[i];
        w_n_pend[i] = w_c_pend[i];
      end else if (CW'(i) == w_pos) begin
        w_n_ent[i]  = w_new;
        w_n_pend[i] = w_m_pend;
      end else begin
        w_n_ent[i]  = w_c_ent[IW'(i - 1)];
        w_n_pend[i] = w_c_pend[IW'(i - 1)];
      end
      w_n_vld[i] = CW'(i) < w_n_cnt;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // NOTE: sequential processes use non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge ap_clk or negedge ap_rst) begin
    if (!ap_rst) begin
      r_vld     <= '0;
      r_pend    <= '0;
      r_hdr_vld <= 1'b0;
      r_gdata   <= '0;
    end else if (ap_ce) begin
      r_vld     <= w_n_vld;
      r_pend    <= w_n_pend;
      r_hdr_vld <= w_rd;
      if (w_gnt_fire) r_gdata <= w_gword;
    end
  end

  // NOTE: payload storage is not reset; only the valid/pending flags are, and
  // nothing reads a payload whose valid flag is clear.
  always_ff @(posedge ap_clk) begin
    if (ap_ce) begin
      r_ent <= w_n_ent;
      if (w_rd) r_hdr <= header_in_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign header_in_read_en_o  = w_rd;
  assign ap_ready             = w_rd;
  assign grant_pkt_write_en_o = w_gnt_fire;
  assign ap_done              = w_gnt_fire;
  assign grant_pkt_data_o     = w_gnt_fire ? w_gword : r_gdata;
  assign ap_idle              = ~ap_rst | (~ap_start & (r_vld == '0));

endmodule

// File: tb/tb_srpt_grant_pkts.sv
// -----------------------------------------------------------------------------
// tb_srpt_grant_pkts
//   Self-checking bench for srpt_grant_pkts. A transaction-level model keeps
//   the tracked messages in a SystemVerilog queue sorted by bytes remaining;
//   a header FIFO is modelled by a queue of words driven onto the FWFT port.
// -----------------------------------------------------------------------------
module tb_srpt_grant_pkts;

  localparam int          MAX = 8;
  localparam logic [31:0] RTT = 32'd5000;

  logic         ap_clk = 1'b0;
  logic         ap_rst, ap_ce, ap_start, ap_continue;
  logic         ap_idle, ap_done, ap_ready;
  logic         header_in_empty_i, header_in_read_en_o;
  logic [124:0] header_in_data_i;
  logic         grant_pkt_full_o, grant_pkt_write_en_o;
  logic [94:0]  grant_pkt_data_o;

  srpt_grant_pkts #(.MAX_ENTRIES(MAX), .RTT_BYTES(RTT)) dut (
    .ap_clk               (ap_clk),
    .ap_rst               (ap_rst),
    .ap_ce                (ap_ce),
    .ap_start             (ap_start),
    .ap_continue          (ap_continue),
    .ap_idle              (ap_idle),
    .ap_done              (ap_done),
    .ap_ready             (ap_ready),
    .header_in_empty_i    (header_in_empty_i),
    .header_in_read_en_o  (header_in_read_en_o),
    .header_in_data_i     (header_in_data_i),
    .grant_pkt_full_o     (grant_pkt_full_o),
    .grant_pkt_write_en_o (grant_pkt_write_en_o),
    .grant_pkt_data_o     (grant_pkt_data_o)
  );

  always #5 ap_clk = ~ap_clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [28:0] key;
    logic [31:0] rem;
    logic [31:0] grant;
    logic [31:0] len;
    bit          pend;
  } ment_t;

  ment_t        mq[$];
  logic [124:0] hq[$];
  bit           m_hv;
  logic [124:0] m_hdr;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-step expected / observed values
  bit          e_rd, e_wr, e_idle;
  logic [94:0] e_data;
  logic        a_rd, a_ready, a_wr, a_done, a_idle;
  logic [94:0] a_data;
  logic [94:0] wr_log[$];
  int          cyc, n_rd, rd_cyc, wr_cyc;

  function automatic logic [124:0] mk_hdr(input logic [14:0] peer, input logic [13:0] lid,
                                          input logic [31:0] len, input logic [31:0] inc,
                                          input logic [31:0] off);
    return {peer, lid, len, inc, off};
  endfunction

  function automatic int m_find(input logic [28:0] key);
    foreach (mq[i]) if (mq[i].key == key) return i;
    return -1;
  endfunction

  function automatic void m_insert(input ment_t e);
    int pos;
    pos = mq.size();
    foreach (mq[i]) if (mq[i].rem > e.rem) begin pos = i; break; end
    mq.insert(pos, e);
  endfunction

  function automatic void m_header(input logic [124:0] h);
    logic [31:0] len, inc, off, rem, gn, g2;
    logic [63:0] sum;
    bit          p2;
    int          idx;
    ment_t       e, old;
    len = h[95:64];
    inc = h[63:32];
    off = h[31:0];
    rem = (off > len) ? 32'd0 : len - off;
    sum = 64'(off) + 64'(RTT);
    gn  = (sum > 64'(len)) ? len : sum[31:0];
    idx = m_find(h[124:96]);
    e.key = h[124:96];
    e.rem = rem;
    e.len = len;
    if (idx < 0) begin
      if (gn > inc) begin
        e.grant = gn;
        e.pend  = 1'b1;
        m_insert(e);
      end
    end else begin
      old = mq[idx];
      g2  = (old.grant > gn) ? old.grant : gn;
      p2  = (g2 > inc) && ((g2 > old.grant) || old.pend);
      mq.delete(idx);
      if (p2 || g2 != len) begin
        e.grant = g2;
        e.pend  = p2;
        m_insert(e);
      end
    end
  endfunction

  // One clock cycle: drive the FIFO head, compute the model's expectations,
  // sample the DUT one time unit later, then advance the model past the edge.
  task automatic step();
    int gi;
    @(negedge ap_clk);
    header_in_empty_i = (hq.size() == 0);
    header_in_data_i  = (hq.size() == 0) ? 125'd0 : hq[0];
    #1;
    gi = -1;
    foreach (mq[i]) if (mq[i].pend) begin gi = i; break; end
    e_wr   = ap_rst && ap_ce && ap_start && !grant_pkt_full_o && (gi >= 0);
    e_data = '0;
    if (gi >= 0) e_data = {mq[gi].key, mq[gi].grant, mq[gi].rem, (gi > 3) ? 2'd3 : 2'(gi)};
    e_rd   = ap_rst && ap_ce && ap_start && (hq.size() > 0) &&
             ((mq.size() + int'(m_hv) < MAX) || (m_find(hq[0][124:96]) >= 0));
    e_idle = !ap_rst || (!ap_start && mq.size() == 0);
    a_rd    = header_in_read_en_o;
    a_ready = ap_ready;
    a_wr    = grant_pkt_write_en_o;
    a_done  = ap_done;
    a_idle  = ap_idle;
    a_data  = grant_pkt_data_o;
    if (a_rd === 1'b1) begin n_rd++; rd_cyc = cyc; end
    if (a_wr === 1'b1) begin wr_log.push_back(a_data); wr_cyc = cyc; end
    @(posedge ap_clk);
    #1;
    cyc++;
    if (ap_ce && ap_rst) begin
      if (e_wr) begin
        mq[gi].pend = 1'b0;
        if (mq[gi].grant == mq[gi].len) mq.delete(gi);
      end
      if (m_hv) m_header(m_hdr);
      m_hv = e_rd;
      if (e_rd) begin
        m_hdr = hq[0];
        void'(hq.pop_front());
      end
    end
  endtask

  task automatic apply_reset();
    ap_rst = 1'b0;
    mq.delete();
    hq.delete();
    m_hv = 1'b0;
    header_in_empty_i = 1'b1;
    header_in_data_i  = '0;
    repeat (2) @(negedge ap_clk);
    #2 ap_rst = 1'b1;
    wr_log.delete();
    n_rd = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    ap_rst = 1'b0; ap_ce = 1'b1; ap_start = 1'b1; ap_continue = 1'b1;
    grant_pkt_full_o  = 1'b0;
    header_in_empty_i = 1'b0;
    header_in_data_i  = mk_hdr(15'd1, 14'd1, 32'd100, 32'd0, 32'd0);
    #3;
    n_checks++;
    if ({header_in_read_en_o, ap_ready, grant_pkt_write_en_o, ap_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 0000",
               {header_in_read_en_o, ap_ready, grant_pkt_write_en_o, ap_done});
    end
    n_checks++;
    if (grant_pkt_data_o !== 95'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", grant_pkt_data_o);
    end
    n_checks++;
    if (ap_idle !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_idle: got %b expected 1", ap_idle);
    end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    ap_start = 1'b1; grant_pkt_full_o = 1'b0;
    hq.push_back(mk_hdr(15'd0, 14'h0CCC, 32'd16, 32'd4, 32'd0));
    repeat (6) step();
    n_checks++;
    if (n_rd !== 1) begin
      n_fail++;
      $display("FAIL single_reads: got %0d expected 1", n_rd);
    end
    n_checks++;
    if (wr_log.size() !== 1) begin
      n_fail++;
      $display("FAIL single_writes: got %0d expected 1", wr_log.size());
    end else begin
      n_checks++;
      if (wr_log[0] !== {15'd0, 14'h0CCC, 32'd16, 32'd16, 2'd0}) begin
        n_fail++;
        $display("FAIL single_word: got %h expected %h", wr_log[0],
                 {15'd0, 14'h0CCC, 32'd16, 32'd16, 2'd0});
      end
      n_checks++;
      if (wr_cyc - rd_cyc !== 2) begin
        n_fail++;
        $display("FAIL single_latency: got %0d expected 2", wr_cyc - rd_cyc);
      end
    end
    ap_start = 1'b0;
    step();
    n_checks++;
    if (a_idle !== 1'b1) begin
      n_fail++;
      $display("FAIL single_idle: got %b expected 1", a_idle);
    end
  endtask

  task automatic test_full_gated();
    apply_reset();
    ap_start = 1'b1; grant_pkt_full_o = 1'b1;
    hq.push_back(mk_hdr(15'd0, 14'h0CCC, 32'd16, 32'd4, 32'd0));
    repeat (6) step();
    n_checks++;
    if (wr_log.size() !== 0) begin
      n_fail++;
      $display("FAIL full_blocks: got %0d writes expected 0", wr_log.size());
    end
    grant_pkt_full_o = 1'b0;
    step();
    n_checks++;
    if (a_wr !== 1'b1 || a_data !== {15'd0, 14'h0CCC, 32'd16, 32'd16, 2'd0}) begin
      n_fail++;
      $display("FAIL full_release: got wr=%b data=%h expected wr=1 data=%h", a_wr, a_data,
               {15'd0, 14'h0CCC, 32'd16, 32'd16, 2'd0});
    end
  endtask

  task automatic test_srpt_order();
    apply_reset();
    ap_start = 1'b1; grant_pkt_full_o = 1'b1;
    hq.push_back(mk_hdr(15'd1, 14'd1, 32'hFFFF_FFFF, 32'd2, 32'd0));
    hq.push_back(mk_hdr(15'd2, 14'd2, 32'd16, 32'd4, 32'd0));
    repeat (6) step();
    grant_pkt_full_o = 1'b0;
    repeat (5) step();
    n_checks++;
    if (wr_log.size() !== 2) begin
      n_fail++;
      $display("FAIL srpt_count: got %0d expected 2", wr_log.size());
    end else begin
      n_checks++;
      if (wr_log[0] !== {15'd2, 14'd2, 32'd16, 32'd16, 2'd0}) begin
        n_fail++;
        $display("FAIL srpt_first: got %h expected %h", wr_log[0],
                 {15'd2, 14'd2, 32'd16, 32'd16, 2'd0});
      end
      n_checks++;
      if (wr_log[1] !== {15'd1, 14'd1, RTT, 32'hFFFF_FFFF, 2'd0}) begin
        n_fail++;
        $display("FAIL srpt_second: got %h expected %h", wr_log[1],
                 {15'd1, 14'd1, RTT, 32'hFFFF_FFFF, 2'd0});
      end
    end
  endtask

  task automatic test_already_granted();
    apply_reset();
    ap_start = 1'b1; grant_pkt_full_o = 1'b0;
    hq.push_back(mk_hdr(15'd3, 14'd7, 32'd16, 32'd16, 32'd0));
    repeat (5) step();
    n_checks++;
    if (n_rd !== 1 || wr_log.size() !== 0) begin
      n_fail++;
      $display("FAIL granted_drop: got reads=%0d writes=%0d expected reads=1 writes=0",
               n_rd, wr_log.size());
    end
    ap_start = 1'b0;
    step();
    n_checks++;
    if (a_idle !== 1'b1) begin
      n_fail++;
      $display("FAIL granted_idle: got %b expected 1", a_idle);
    end
  endtask

  task automatic test_queue_full();
    apply_reset();
    ap_start = 1'b1; grant_pkt_full_o = 1'b1;
    for (int i = 0; i <= MAX; i++)
      hq.push_back(mk_hdr(15'(i + 10), 14'(i), 32'hFFFF_0000, 32'd0, 32'd0));
    repeat (20) step();
    n_checks++;
    if (hq.size() !== 1 || a_rd !== 1'b0 || header_in_empty_i !== 1'b0) begin
      n_fail++;
      $display("FAIL qfull_hold: got left=%0d rd=%b empty=%b expected left=1 rd=0 empty=0",
               hq.size(), a_rd, header_in_empty_i);
    end
    // Equal remaining: grants leave in arrival order, priority saturating at 3.
    grant_pkt_full_o = 1'b0;
    repeat (MAX + 2) step();
    n_checks++;
    if (wr_log.size() !== MAX) begin
      n_fail++;
      $display("FAIL qfull_writes: got %0d expected %0d", wr_log.size(), MAX);
    end else begin
      for (int i = 0; i < MAX; i++) begin
        n_checks++;
        if (wr_log[i] !== {15'(i + 10), 14'(i), RTT, 32'hFFFF_0000, (i > 3) ? 2'd3 : 2'(i)}) begin
          n_fail++;
          $display("FAIL qfull_order[%0d]: got %h expected %h", i, wr_log[i],
                   {15'(i + 10), 14'(i), RTT, 32'hFFFF_0000, (i > 3) ? 2'd3 : 2'(i)});
        end
      end
    end
  endtask

  task automatic test_random();
    int k;
    logic [31:0] len, off, inc;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      ap_start         = ($urandom_range(0, 9) != 0);
      ap_ce            = ($urandom_range(0, 9) != 0);
      grant_pkt_full_o = ($urandom_range(0, 9) < 3);
      if (hq.size() < 4 && $urandom_range(0, 9) < 4) begin
        k = $urandom_range(0, 11);
        if ($urandom_range(0, 15) == 0) begin
          len = 32'hFFFF_FFFF;
          off = $urandom();
          inc = $urandom();
        end else begin
          len = $urandom_range(0, 20000);
          off = $urandom_range(0, len + 100);
          inc = $urandom_range(0, len + 6000);
        end
        hq.push_back(mk_hdr(15'(k), 14'(k * 3), len, inc, off));
      end
      step();
      n_checks++;
      if ({a_rd, a_ready, a_wr, a_done, a_idle} !== {e_rd, e_rd, e_wr, e_wr, e_idle}) begin
        n_fail++;
        $display("FAIL rand_ctl@%0d: got rd/rdy/wr/done/idle=%b expected %b", c,
                 {a_rd, a_ready, a_wr, a_done, a_idle}, {e_rd, e_rd, e_wr, e_wr, e_idle});
      end
      if (e_wr) begin
        n_checks++;
        if (a_data !== e_data) begin
          n_fail++;
          $display("FAIL rand_data@%0d: got %h expected %h", c, a_data, e_data);
        end
      end
    end
    ap_ce = 1'b1;
  endtask

  task automatic test_async_reset();
    apply_reset();
    ap_ce = 1'b1; ap_start = 1'b1; grant_pkt_full_o = 1'b1;
    for (int i = 0; i < 3; i++)
      hq.push_back(mk_hdr(15'(i + 40), 14'(i), 32'd9000, 32'd0, 32'(i * 100)));
    repeat (6) step();
    hq.push_back(mk_hdr(15'd50, 14'd50, 32'd9000, 32'd0, 32'd0));
    @(negedge ap_clk);
    header_in_empty_i = 1'b0;
    header_in_data_i  = hq[0];
    grant_pkt_full_o  = 1'b0;
    #1;
    n_checks++;
    if (grant_pkt_write_en_o !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pending: got wr=%b expected 1", grant_pkt_write_en_o);
    end
    #1 ap_rst = 1'b0;
    #1;
    n_checks++;
    if ({header_in_read_en_o, ap_ready, grant_pkt_write_en_o, ap_done, ap_idle} !== 5'b00001 ||
        grant_pkt_data_o !== 95'd0) begin
      n_fail++;
      $display("FAIL arst_clear: got rd/rdy/wr/done/idle=%b data=%h expected 00001 data=0",
               {header_in_read_en_o, ap_ready, grant_pkt_write_en_o, ap_done, ap_idle},
               grant_pkt_data_o);
    end
    mq.delete();
    hq.delete();
    m_hv = 1'b0;
    header_in_empty_i = 1'b1;
    @(negedge ap_clk);
    #2 ap_rst = 1'b1;
    wr_log.delete();
    repeat (8) step();
    n_checks++;
    if (wr_log.size() !== 0) begin
      n_fail++;
      $display("FAIL arst_after: got %0d writes expected 0", wr_log.size());
    end
  endtask

  initial begin
    cyc = 0; n_rd = 0; rd_cyc = 0; wr_cyc = 0; m_hv = 1'b0;
    test_reset();
    test_single();
    test_full_gated();
    test_srpt_order();
    test_already_granted();
    test_queue_full();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
